// File: rtl/gr_file_sb.sv
// General-register file with byte-lane writeback, combinational bypassed reads
// and a per-register outstanding-write scoreboard for RAW hazard detection.
module gr_file_sb #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int PEND_W  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [AW-1:0]      ra_addr,
  input  logic [AW-1:0]      rb_addr,
  output logic [WIDTH-1:0]   ra_data,
  output logic [WIDTH-1:0]   rb_data,
  output logic               ra_busy,
  output logic               rb_busy,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_addr,
  output logic               iss_full,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               wr_retire,
  output logic               sb_err,
  input  logic [AW-1:0]      dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);

  localparam int NB = WIDTH / 8;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  regs_q [NREG];
  logic [WIDTH-1:0]  regs_d [NREG];
  logic [PEND_W-1:0] cnt_q  [NREG];
  logic [PEND_W-1:0] cnt_d  [NREG];
  logic              sb_err_q, sb_err_d;

  logic wr_act, ret_act, ra_hit, rb_hit;

  function automatic logic is_r0(input logic [AW-1:0] addr);
    return (ZERO_R0 != 0) && (addr == '0);
  endfunction

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] new_v,
                                                  input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    for (int i = 0; i < NB; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  // A count of one that retires this cycle no longer blocks the reader.
  function automatic logic busy_of(input logic [PEND_W-1:0] cnt,
                                   input logic              retiring,
                                   input logic              zero_reg);
    return !zero_reg && (cnt != '0) && !(retiring && (cnt == PEND_W'(1)));
  endfunction

  assign wr_act  = enable && wr_en && !is_r0(wr_addr);
  assign ret_act = enable && wr_en && wr_retire && !is_r0(wr_addr);
  assign ra_hit  = wr_act && (wr_addr == ra_addr);
  assign rb_hit  = wr_act && (wr_addr == rb_addr);

  assign ra_data = is_r0(ra_addr) ? '0 :
                   ra_hit ? lane_merge(regs_q[ra_addr], wr_data, wr_be) : regs_q[ra_addr];
  assign rb_data = is_r0(rb_addr) ? '0 :
                   rb_hit ? lane_merge(regs_q[rb_addr], wr_data, wr_be) : regs_q[rb_addr];

  assign ra_busy  = busy_of(cnt_q[ra_addr], ret_act && (wr_addr == ra_addr), is_r0(ra_addr));
  assign rb_busy  = busy_of(cnt_q[rb_addr], ret_act && (wr_addr == rb_addr), is_r0(rb_addr));
  assign iss_full = !is_r0(iss_addr) && (cnt_q[iss_addr] == CNT_MAX);
  assign sb_err   = sb_err_q;
  assign dbg_data = regs_q[dbg_addr];

  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      cnt_d[r]  = cnt_q[r];
    end
    if (wr_act)
      regs_d[wr_addr] = lane_merge(regs_q[wr_addr], wr_data, wr_be);
    if (ret_act && (cnt_q[wr_addr] == '0))
      sb_err_d = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = enable && iss_en && (iss_addr == AW'(r)) && !iss_full && !is_r0(AW'(r));
      dec = ret_act && (wr_addr == AW'(r)) && (cnt_q[r] != '0);
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else if (enable) begin
      sb_err_q <= sb_err_d;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_gr_file_sb.sv
// Directed bench for gr_file_sb: byte lanes, bypass, hazard busy, counter
// saturation, simultaneous issue/retire, sticky error, enable hold, reset, ZERO_R0.
module tb_gr_file_sb;

  logic        clock, reset, enable;
  logic [2:0]  ra_addr, rb_addr, iss_addr, wr_addr, dbg_addr;
  logic [15:0] ra_data, rb_data, wr_data, dbg_data;
  logic        ra_busy, rb_busy, iss_en, iss_full, wr_en, wr_retire, sb_err;
  logic [1:0]  wr_be;
  logic [15:0] z_ra_data, z_rb_data, z_dbg_data;
  logic        z_ra_busy, z_rb_busy, z_iss_full, z_sb_err;

  int checks = 0;
  int failures = 0;

  gr_file_sb #(.WIDTH(16), .NREG(8), .AW(3), .PEND_W(2), .ZERO_R0(0)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .ra_busy(ra_busy), .rb_busy(rb_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_retire(wr_retire), .sb_err(sb_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  gr_file_sb #(.WIDTH(16), .NREG(8), .AW(3), .PEND_W(2), .ZERO_R0(1)) dut_z (
    .clock(clock), .reset(reset), .enable(enable),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(z_ra_data), .rb_data(z_rb_data),
    .ra_busy(z_ra_busy), .rb_busy(z_rb_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(z_iss_full),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_retire(wr_retire), .sb_err(z_sb_err), .dbg_addr(dbg_addr), .dbg_data(z_dbg_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0; wr_en = 1'b0; wr_retire = 1'b0; wr_be = 2'b00; wr_data = 16'h0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; idle();
    ra_addr = 3'd0; rb_addr = 3'd0; iss_addr = 3'd0; wr_addr = 3'd0; dbg_addr = 3'd0;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_ra_data", ra_data, 16'h0);
    check_eq("rst_ra_busy", ra_busy, 1'b0);
    check_eq("rst_sb_err", sb_err, 1'b0);
    check_eq("rst_iss_full", iss_full, 1'b0);

    // LDIH / LDIL byte lanes
    wr_en = 1'b1; wr_addr = 3'd1; wr_be = 2'b11; wr_data = 16'h00FF;
    tick();
    wr_be = 2'b10; wr_data = 16'hFF00; ra_addr = 3'd1; dbg_addr = 3'd1;
    #1;
    check_eq("ldih_bypass", ra_data, 16'hFFFF);
    check_eq("ldih_dbg_before", dbg_data, 16'h00FF);
    tick();
    wr_be = 2'b01; wr_data = 16'h0012;
    #1;
    check_eq("ldih_storage", dbg_data, 16'hFFFF);
    check_eq("ldil_bypass", ra_data, 16'hFF12);
    tick();
    idle();
    #1;
    check_eq("ldil_storage", ra_data, 16'hFF12);

    // Hazard stall on gr3
    iss_en = 1'b1; iss_addr = 3'd3; rb_addr = 3'd3;
    tick();
    iss_en = 1'b0;
    #1;
    check_eq("haz_busy0", rb_busy, 1'b1);
    tick(); tick();
    check_eq("haz_busy2", rb_busy, 1'b1);
    wr_en = 1'b1; wr_retire = 1'b1; wr_addr = 3'd3; wr_be = 2'b11; wr_data = 16'h1234;
    #1;
    check_eq("haz_ret_busy", rb_busy, 1'b0);
    check_eq("haz_ret_data", rb_data, 16'h1234);
    tick();
    idle();
    #1;
    check_eq("haz_after_busy", rb_busy, 1'b0);
    check_eq("haz_after_data", rb_data, 16'h1234);

    // Counter saturation on gr2
    iss_en = 1'b1; iss_addr = 3'd2; ra_addr = 3'd2;
    #1;
    check_eq("sat_full0", iss_full, 1'b0);
    tick(); tick(); tick();
    check_eq("sat_full3", iss_full, 1'b1);
    tick();
    iss_en = 1'b0;
    #1;
    check_eq("sat_refused", iss_full, 1'b1);
    wr_en = 1'b1; wr_retire = 1'b1; wr_addr = 3'd2; wr_be = 2'b00;
    #1;
    check_eq("sat_ret1_busy", ra_busy, 1'b1);
    tick();
    check_eq("sat_ret2_busy", ra_busy, 1'b1);
    check_eq("sat_ret2_full", iss_full, 1'b0);
    tick();
    check_eq("sat_ret3_busy", ra_busy, 1'b0);
    tick();
    idle();
    #1;
    check_eq("sat_end_busy", ra_busy, 1'b0);
    check_eq("sat_no_err", sb_err, 1'b0);
    check_eq("sat_be0_data", ra_data, 16'h0);

    // Simultaneous issue and retire on gr5
    iss_en = 1'b1; iss_addr = 3'd5; ra_addr = 3'd5;
    tick();
    wr_en = 1'b1; wr_retire = 1'b1; wr_addr = 3'd5; wr_be = 2'b00;
    tick();
    iss_en = 1'b0; wr_en = 1'b0; wr_retire = 1'b0;
    #1;
    check_eq("simul_busy", ra_busy, 1'b1);
    wr_en = 1'b1; wr_retire = 1'b1;
    #1;
    check_eq("simul_ret_busy", ra_busy, 1'b0);
    tick();
    idle();
    #1;
    check_eq("simul_cleared", ra_busy, 1'b0);
    check_eq("simul_no_err", sb_err, 1'b0);

    // Pending count on gr7 to be discarded by reset later
    iss_en = 1'b1; iss_addr = 3'd7; rb_addr = 3'd7;
    tick();
    idle();
    #1;
    check_eq("g7_busy", rb_busy, 1'b1);

    // Retire against zero counter
    wr_en = 1'b1; wr_retire = 1'b1; wr_addr = 3'd4; wr_be = 2'b11; wr_data = 16'hABCD;
    dbg_addr = 3'd4;
    #1;
    check_eq("err_before", sb_err, 1'b0);
    tick();
    idle();
    #1;
    check_eq("err_set", sb_err, 1'b1);
    check_eq("err_data", dbg_data, 16'hABCD);

    // enable=0 holds everything and suppresses bypass
    enable = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_be = 2'b11; wr_data = 16'h5555;
    iss_en = 1'b1; iss_addr = 3'd6; ra_addr = 3'd4;
    #1;
    check_eq("en0_no_bypass", ra_data, 16'hABCD);
    tick();
    idle();
    enable = 1'b1;
    ra_addr = 3'd6;
    #1;
    check_eq("en0_data_held", dbg_data, 16'hABCD);
    check_eq("en0_no_issue", ra_busy, 1'b0);
    check_eq("en0_err_held", sb_err, 1'b1);

    // Reset clears data, counts and error
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst2_err", sb_err, 1'b0);
    check_eq("rst2_busy7", rb_busy, 1'b0);
    check_eq("rst2_dbg4", dbg_data, 16'h0);
    dbg_addr = 3'd1;
    #1;
    check_eq("rst2_dbg1", dbg_data, 16'h0);

    // Register zero: hardwired in dut_z, ordinary in dut
    wr_en = 1'b1; wr_addr = 3'd0; wr_be = 2'b11; wr_data = 16'hBEEF;
    iss_en = 1'b1; iss_addr = 3'd0; ra_addr = 3'd0; dbg_addr = 3'd0;
    #1;
    check_eq("z_bypass", z_ra_data, 16'h0);
    check_eq("z_iss_full", z_iss_full, 1'b0);
    check_eq("nz_bypass", ra_data, 16'hBEEF);
    tick();
    idle();
    #1;
    check_eq("z_read", z_ra_data, 16'h0);
    check_eq("z_dbg", z_dbg_data, 16'h0);
    check_eq("z_busy", z_ra_busy, 1'b0);
    check_eq("nz_read", ra_data, 16'hBEEF);
    check_eq("nz_busy", ra_busy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
